text_grid_buffer: RTL
=====================

Name: text_grid_buffer

Overview:
- Character store sitting directly downstream of the terminal controller.
- Accepts its single-character write port (tg_we/tg_addr/tg_input) and its scroll_up/scroll_down pulses.
- Holds the full SCREEN_WIDTH x SCREEN_HEIGHT ASCII grid and maintains a scroll offset.
- Serves a VIEW_ROWS-high window to the pixel renderer through a fixed-latency read port.
- After every reset it sweeps the grid to spaces before accepting traffic.

Parameters:
SCREEN_WIDTH, 76, columns per row; must match the terminal controller.
SCREEN_HEIGHT, 44, rows held in the grid.
VIEW_ROWS, 24, rows visible to the renderer; must satisfy 1 <= VIEW_ROWS <= SCREEN_HEIGHT.

Ports:
pixel_clk_in  in  1  sole clock.
rst_in  in  1  synchronous, active-low reset.
tg_we  in  1  write strobe from the terminal controller.
tg_addr  in  $clog2(SCREEN_WIDTH*SCREEN_HEIGHT)  linear grid address, row*SCREEN_WIDTH+col.
tg_input  in  8  ASCII byte to store.
scroll_up  in  1  one-cycle pulse; moves the view window toward row 0.
scroll_down  in  1  one-cycle pulse; moves the view window toward the last row.
rd_req  in  1  renderer read request.
rd_col  in  $clog2(SCREEN_WIDTH)  column in view coordinates.
rd_row  in  $clog2(VIEW_ROWS)  row in view coordinates.
rd_valid  out  1  read data valid, two cycles after rd_req.
rd_char  out  8  ASCII byte returned.
scroll_offset  out  $clog2(SCREEN_HEIGHT)  current top grid row of the view window.
busy  out  1  high while the clear sweep runs.

Behaviour:
- Reset: applies while rst_in=0, sampled on a pixel_clk_in edge.
  - Outputs: rd_valid=0, rd_char=32, scroll_offset=0, busy=1.
  - The FSM enters CLEAR with the sweep counter at 0.
  - Read pipeline and in-flight requests are flushed. A reset mid-sweep or mid-operation restarts the sweep from address 0.
- FSM states: CLEAR -> RUN.
  - CLEAR: writes 32 to address counter, one address per cycle, counter 0..SCREEN_WIDTH*SCREEN_HEIGHT-1.
  - The cycle after the write to the last address, busy drops to 0 and the FSM enters RUN.
  - Sweep duration is exactly SCREEN_WIDTH*SCREEN_HEIGHT cycles (3344 at defaults).
- Writes during CLEAR: tg_we is ignored and the data is dropped (not queued).
- Writes in RUN: tg_we=1 with tg_addr < SCREEN_WIDTH*SCREEN_HEIGHT stores tg_input at the next edge. Addresses >= SCREEN_WIDTH*SCREEN_HEIGHT are ignored.
- Scroll rules:
  - MAX_OFF = SCREEN_HEIGHT-VIEW_ROWS (20 at defaults).
  - scroll_down increments scroll_offset, saturating at MAX_OFF.
  - scroll_up decrements scroll_offset, saturating at 0.
  - Both pulses in the same cycle: no change.
  - Scroll pulses during CLEAR are ignored.
  - The offset update is visible on scroll_offset one cycle after the pulse.
- Read pipeline (2 cycles):
  - Stage 0 (request cycle): compute the grid address as (rd_row+scroll_offset)*SCREEN_WIDTH+rd_col, using the offset value registered at that edge. Also flag out-of-range requests (rd_col>=SCREEN_WIDTH or rd_row>=VIEW_ROWS).
  - Stage 1: synchronous memory read.
  - Stage 2: rd_valid=1 and rd_char = memory byte, or 32 if the request was out of range.
  - Fully pipelined: one request accepted per cycle, and a response is produced for every request.
  - rd_req during CLEAR: still returns rd_valid two cycles later, with rd_char=32.
- Read/write collision: the memory is read-first. A read issued in the same cycle as a write to the same address returns the old byte. A read issued one or more cycles later returns the new byte.
- Arithmetic: the address computation uses full-width unsigned intermediates. With VIEW_ROWS<=SCREEN_HEIGHT and the offset clamped, in-range requests always map inside the grid.
- Implementation: the memory is a single-port-write, single-port-read block RAM, 8 bits wide, SCREEN_WIDTH*SCREEN_HEIGHT deep. No other storage scales with the grid.

Test Plan:
- Reset release:
  - Hold rst_in=0 for 3 cycles, then release. busy stays 1 for exactly 3344 cycles, then drops.
  - Random rd_req during the sweep returns 32.
  - After busy falls, a read of (col 75, row 23) returns 32.
- Write/readback:
  - In RUN, write tg_addr=76*2+5 with 0x61.
  - rd_req (col 5, row 2) issued 1 cycle later -> rd_valid=1 two cycles after the request, rd_char=0x61.
  - The same-cycle request returns 32.
- Scroll saturation and mapping:
  - 25 scroll_down pulses -> scroll_offset=20. A read of (col 0, row 0) then returns the byte at address 20*76.
  - 25 scroll_up pulses -> scroll_offset=0.
  - Simultaneous up+down -> offset unchanged.
- Bounds:
  - A write to tg_addr=3344 leaves all cells unchanged.
  - rd_col=80 or rd_row=30 -> rd_valid=1, rd_char=32.
- Mid-operation reset:
  - Write 0x7A to address 100 and set scroll_offset=7, then pulse rst_in=0 for 1 cycle partway through a read burst.
  - Pipeline flushes (rd_valid=0 the next cycle), offset=0, sweep restarts at 0.
  - Address 100 reads 32 after busy falls.
- Back-to-back reads: rd_req held high for 10 cycles over consecutive columns -> 10 consecutive rd_valid cycles, in order, with no gaps.

Source files
------------

// File: rtl/text_grid_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : text_grid_buffer_if
// Purpose  : Bundles the terminal-controller write port, scroll pulses and
//            the renderer read port of the text grid buffer.
// Ports    : master - drives tg_we/tg_addr/tg_input, scroll_up/scroll_down,
//                     rd_req/rd_col/rd_row; observes rd_valid/rd_char,
//                     scroll_offset, busy.
//            slave  - the buffer side, directions mirrored.
// Revision : 1.0 - initial release
// ============================================================================
interface text_grid_buffer_if #(
  parameter int SCREEN_WIDTH  = 76,
  parameter int SCREEN_HEIGHT = 44,
  parameter int VIEW_ROWS     = 24
);
  localparam int CELLS  = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int ADDR_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int COL_W  = (SCREEN_WIDTH > 1) ? $clog2(SCREEN_WIDTH) : 1;
  localparam int ROW_W  = (VIEW_ROWS > 1) ? $clog2(VIEW_ROWS) : 1;
  localparam int OFF_W  = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;

  logic              tg_we;
  logic [ADDR_W-1:0] tg_addr;
  logic [7:0]        tg_input;
  logic              scroll_up;
  logic              scroll_down;
  logic              rd_req;
  logic [COL_W-1:0]  rd_col;
  logic [ROW_W-1:0]  rd_row;
  logic              rd_valid;
  logic [7:0]        rd_char;
  logic [OFF_W-1:0]  scroll_offset;
  logic              busy;

  modport master (
    output tg_we, tg_addr, tg_input, scroll_up, scroll_down,
           rd_req, rd_col, rd_row,
    input  rd_valid, rd_char, scroll_offset, busy
  );

  modport slave (
    input  tg_we, tg_addr, tg_input, scroll_up, scroll_down,
           rd_req, rd_col, rd_row,
    output rd_valid, rd_char, scroll_offset, busy
  );
endinterface
`default_nettype wire

// File: rtl/text_grid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : text_grid_buffer
// Purpose  : SCREEN_WIDTH x SCREEN_HEIGHT ASCII character store with a
//            scrollable VIEW_ROWS-high window and a 2-cycle read port.
//            Sweeps the whole grid to spaces after every reset.
// Ports    : pixel_clk_in - sole clock
//            rst_in       - synchronous active-low reset
//            bus          - text_grid_buffer_if.slave (write port, scroll
//                           pulses, read port, scroll_offset, busy)
// Revision : 1.0 - initial release
// ============================================================================
module text_grid_buffer #(
  parameter int SCREEN_WIDTH  = 76,
  parameter int SCREEN_HEIGHT = 44,
  parameter int VIEW_ROWS     = 24
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  text_grid_buffer_if.slave   bus
);
  localparam int CELLS  = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int ADDR_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int OFF_W  = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [OFF_W-1:0]  MAX_OFF   = OFF_W'(SCREEN_HEIGHT - VIEW_ROWS);
  localparam logic [7:0]        SPACE     = 8'd32;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic [OFF_W-1:0]  offset;

  logic [7:0]        mem [CELLS];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;

  logic              rd_oob;
  logic [ADDR_W-1:0] rd_addr;
  logic              s1_valid;
  logic              s1_blank;
  logic [7:0]        s1_data;
  logic              rd_valid_q;
  logic [7:0]        rd_char_q;

  // State register and sweep counter
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end

  // Next state and write-port steering: the sweep owns the port in CLEAR,
  // so controller writes arriving then are simply dropped.
  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_waddr  = bus.tg_addr;
    mem_wdata  = bus.tg_input;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        mem_wdata = SPACE;
        if (clr_cnt == LAST_ADDR) state_next = RUN;
      end
      RUN: begin
        mem_we = bus.tg_we && (32'(bus.tg_addr) < 32'(CELLS));
      end
    endcase
  end

  // Scroll offset, saturating at both ends; opposing pulses cancel.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      offset <= '0;
    end else if (state == RUN) begin
      if (bus.scroll_down && !bus.scroll_up && (offset < MAX_OFF))
        offset <= offset + OFF_W'(1);
      else if (bus.scroll_up && !bus.scroll_down && (offset != '0))
        offset <= offset - OFF_W'(1);
    end
  end

  // Request-cycle address mapping. Out-of-range requests are steered to
  // address 0 so the RAM index always stays inside the array.
  always_comb begin
    rd_oob  = (32'(bus.rd_col) >= 32'(SCREEN_WIDTH)) ||
              (32'(bus.rd_row) >= 32'(VIEW_ROWS));
    rd_addr = rd_oob ? '0 :
              ADDR_W'((32'(bus.rd_row) + 32'(offset)) * 32'(SCREEN_WIDTH)
                      + 32'(bus.rd_col));
  end

  // Block RAM: the read is launched on the same edge that samples the
  // request, so a same-cycle write to that address is seen as the old byte.
  always_ff @(posedge pixel_clk_in) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    s1_data <= mem[rd_addr];
  end

  // Valid/blank pipeline alongside the RAM; requests seen during the sweep
  // are answered with a space because the grid is not yet initialised.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      s1_valid   <= 1'b0;
      s1_blank   <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_char_q  <= SPACE;
    end else begin
      s1_valid   <= bus.rd_req;
      s1_blank   <= rd_oob || (state == CLEAR);
      rd_valid_q <= s1_valid;
      rd_char_q  <= s1_blank ? SPACE : s1_data;
    end
  end

  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_char       = rd_char_q;
  assign bus.scroll_offset = offset;
  assign bus.busy          = (state == CLEAR);
endmodule
`default_nettype wire
